// File: rtl/upsample.sv
// rtl/upsample.sv - zero-order-hold sample-rate upconverter with one-entry prefetch
module upsample #(
  parameter int SAMPLE_RATE_IN  = 20_000,
  parameter int SAMPLE_RATE_OUT = 122_880,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  signal_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] signal_axis_tdata,
  output logic                  signal_axis_tready,
  input  logic                  upsample_axis_tready,
  output logic                  upsample_axis_tvalid,
  output logic [DATA_WIDTH-1:0] upsample_axis_tdata,
  input  logic                  underrun_clr_in,
  output logic                  underrun_out
);

  // One extra bit so phase + rate_in never wraps before the compare.
  localparam int PW = $clog2(SAMPLE_RATE_OUT) + 1;
  localparam logic [PW-1:0] RATE_IN  = PW'(SAMPLE_RATE_IN);
  localparam logic [PW-1:0] RATE_OUT = PW'(SAMPLE_RATE_OUT);

  logic [DATA_WIDTH-1:0] r_next_data;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_next_valid;
  logic                  r_hold_valid;
  logic [PW-1:0]         r_phase;
  logic                  r_underrun;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_load;
  logic                  w_due;
  logic                  w_advance;
  logic                  w_underrun_set;
  logic [PW-1:0]         w_phase_sum;

  assign signal_axis_tready   = ~r_next_valid;
  assign upsample_axis_tvalid = r_hold_valid;
  assign upsample_axis_tdata  = r_hold_data;
  assign underrun_out         = r_underrun;

  assign w_in_hs        = signal_axis_tvalid & ~r_next_valid;
  assign w_out_hs       = r_hold_valid & upsample_axis_tready;
  // Hold slot empty with a sample waiting: start a fresh repeat run at phase 0.
  assign w_load         = ~r_hold_valid & r_next_valid;
  assign w_phase_sum    = r_phase + RATE_IN;
  // The beat being sent is the last repeat of the held sample.
  assign w_due          = w_out_hs & (w_phase_sum >= RATE_OUT);
  assign w_advance      = w_due & r_next_valid;
  assign w_underrun_set = w_due & ~r_next_valid;

  // Control state: prefetch/hold occupancy and the fractional phase accumulator
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_next_valid <= 1'b0;
      r_hold_valid <= 1'b0;
      r_phase      <= '0;
    end else begin
      // Accept only happens while next is empty, so it never collides with
      // the load/advance paths below, which both require next to be full.
      if (w_in_hs) begin
        r_next_valid <= 1'b1;
      end
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_next_valid <= 1'b0;
        r_phase      <= '0;
      end else if (w_out_hs) begin
        if (!w_due) begin
          r_phase <= w_phase_sum;
        end else if (r_next_valid) begin
          r_next_valid <= 1'b0;
          r_phase      <= w_phase_sum - RATE_OUT;
        end else begin
          // Starved: drop the held sample so the next one restarts at phase 0.
          r_hold_valid <= 1'b0;
          r_phase      <= '0;
        end
      end
    end
  end

  // Sample data path; qualified by the valid flags so no reset is needed
  always_ff @(posedge clk_in) begin
    if (w_in_hs) begin
      r_next_data <= signal_axis_tdata;
    end
    if (w_load || w_advance) begin
      r_hold_data <= r_next_data;
    end
  end

  // Sticky starvation flag; a coincident set beats the clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr_in) begin
      r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_upsample.sv
// tb/tb_upsample.sv - table-driven scoreboard bench for the zero-order-hold upsampler
module tb_upsample;

  typedef struct {
    logic [31:0] data;
    int          reps;
  } vec_t;

  logic        clk;
  logic        rst_in;
  logic        signal_axis_tvalid;
  logic [31:0] signal_axis_tdata;
  logic        signal_axis_tready;
  logic        upsample_axis_tready;
  logic        upsample_axis_tvalid;
  logic [31:0] upsample_axis_tdata;
  logic        underrun_clr_in;
  logic        underrun_out;

  upsample #(
    .SAMPLE_RATE_IN (20_000),
    .SAMPLE_RATE_OUT(122_880),
    .DATA_WIDTH     (32)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_in),
    .signal_axis_tvalid  (signal_axis_tvalid),
    .signal_axis_tdata   (signal_axis_tdata),
    .signal_axis_tready  (signal_axis_tready),
    .upsample_axis_tready(upsample_axis_tready),
    .upsample_axis_tvalid(upsample_axis_tvalid),
    .upsample_axis_tdata (upsample_axis_tdata),
    .underrun_clr_in     (underrun_clr_in),
    .underrun_out        (underrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          cyc;
  int          beats;
  int          first_acc;
  int          first_tv;
  int          last_gaps;
  bit          acc_now;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic [31:0] q_exp[$];
  vec_t        stim[$];
  vec_t        vec[7];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Observe the handshakes that the coming posedge will perform, then advance.
  task automatic tick();
    logic [31:0] e;
    acc_now = 1'b0;
    if (prev_stall) begin
      check_eq("stall_tvalid", 32'(upsample_axis_tvalid), 32'd1);
      check_eq("stall_tdata", upsample_axis_tdata, prev_data);
    end
    prev_stall = upsample_axis_tvalid & ~upsample_axis_tready;
    prev_data  = upsample_axis_tdata;
    if (upsample_axis_tvalid && upsample_axis_tready) begin
      beats++;
      if (q_exp.size() == 0) begin
        check_eq("extra_beat", upsample_axis_tdata, 32'hxxxx_xxxx);
      end else begin
        e = q_exp.pop_front();
        check_eq("beat_data", upsample_axis_tdata, e);
      end
    end
    if (signal_axis_tvalid && signal_axis_tready) acc_now = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_stream(input bit rnd, input bit chk_ur, input bit clr_on_last);
    int idx;
    int guard;
    int cur;
    int gaps;
    int ur_bad;
    idx = 0; guard = 0; gaps = 0; ur_bad = 0;
    first_acc = -1; first_tv = -1;
    while ((idx < stim.size() || q_exp.size() > 0) && guard < 3000) begin
      signal_axis_tvalid   = (idx < stim.size());
      signal_axis_tdata    = (idx < stim.size()) ? stim[idx].data : 32'd0;
      upsample_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      underrun_clr_in      = clr_on_last && upsample_axis_tvalid && upsample_axis_tready
                             && (q_exp.size() == 1) && (idx == stim.size());
      cur = cyc;
      if (upsample_axis_tvalid && first_tv < 0) first_tv = cur;
      if (first_tv >= 0 && !upsample_axis_tvalid && q_exp.size() > 0) gaps++;
      if (chk_ur && underrun_out) ur_bad++;
      tick();
      if (acc_now) begin
        if (first_acc < 0) first_acc = cur;
        for (int r = 0; r < stim[idx].reps; r++) q_exp.push_back(stim[idx].data);
        idx++;
      end
      guard++;
    end
    signal_axis_tvalid = 1'b0;
    underrun_clr_in    = 1'b0;
    upsample_axis_tready = 1'b1;
    check_eq("stream_done", 32'(guard < 3000), 32'd1);
    if (chk_ur) check_eq("underrun_mid", 32'(ur_bad), 32'd0);
    last_gaps = gaps;
  endtask

  task automatic idle(input int n);
    signal_axis_tvalid   = 1'b0;
    upsample_axis_tready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    signal_axis_tvalid   = 1'b0;
    upsample_axis_tready = 1'b1;
    underrun_clr_in      = 1'b1;
    tick();
    underrun_clr_in      = 1'b0;
    check_eq("clr_alone", 32'(underrun_out), 32'd0);
  endtask

  task automatic feed_stalled(input logic [31:0] d);
    int g;
    g = 0;
    signal_axis_tvalid   = 1'b1;
    signal_axis_tdata    = d;
    upsample_axis_tready = 1'b0;
    acc_now = 1'b0;
    while (!acc_now && g < 20) begin
      tick();
      g++;
    end
    signal_axis_tvalid = 1'b0;
    check_eq("stalled_accept", 32'(acc_now), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; beats = 0;
    prev_stall = 1'b0; prev_data = '0;
    rst_in = 1'b1;
    signal_axis_tvalid = 1'b0; signal_axis_tdata = '0;
    upsample_axis_tready = 1'b1; underrun_clr_in = 1'b0;

    for (int i = 0; i < 7; i++) vec[i].data = 32'(i + 1);
    vec[0].reps = 7; vec[1].reps = 6; vec[2].reps = 6; vec[3].reps = 6;
    vec[4].reps = 6; vec[5].reps = 6; vec[6].reps = 7;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_tvalid", 32'(upsample_axis_tvalid), 32'd0);
    check_eq("rst_underrun", 32'(underrun_out), 32'd0);
    rst_in = 1'b0;
    @(negedge clk);
    check_eq("rst_tready", 32'(signal_axis_tready), 32'd1);

    // Continuous feed, downstream always ready
    stim.delete();
    for (int i = 0; i < 7; i++) stim.push_back(vec[i]);
    beats = 0;
    run_stream(1'b0, 1'b1, 1'b0);
    check_eq("beats_44", 32'(beats), 32'd44);
    check_eq("first_latency", 32'(first_tv - first_acc), 32'd2);
    check_eq("no_gaps", 32'(last_gaps), 32'd0);
    check_eq("underrun_end", 32'(underrun_out), 32'd1);
    idle(3);
    check_eq("idle_tvalid", 32'(upsample_axis_tvalid), 32'd0);

    // Same feed, downstream ready about half the time
    pulse_clr();
    beats = 0;
    run_stream(1'b1, 1'b1, 1'b0);
    check_eq("rnd_beats_44", 32'(beats), 32'd44);
    check_eq("rnd_underrun_end", 32'(underrun_out), 32'd1);

    // Single sample then idle: underrun, then restart at phase 0
    pulse_clr();
    stim.delete();
    stim.push_back('{data: 32'hA5A5_0001, reps: 7});
    beats = 0;
    run_stream(1'b0, 1'b1, 1'b0);
    idle(20);
    check_eq("single_beats", 32'(beats), 32'd7);
    check_eq("single_tvalid", 32'(upsample_axis_tvalid), 32'd0);
    check_eq("single_underrun", 32'(underrun_out), 32'd1);
    stim.delete();
    stim.push_back('{data: 32'h0000_0002, reps: 7});
    beats = 0;
    run_stream(1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("restart_beats", 32'(beats), 32'd7);

    // Clear coinciding with a new underrun: set wins; later clear works
    pulse_clr();
    stim.delete();
    stim.push_back('{data: 32'h0000_0055, reps: 7});
    run_stream(1'b0, 1'b1, 1'b1);
    check_eq("clr_vs_set", 32'(underrun_out), 32'd1);
    pulse_clr();

    // Mid-stream reset with hold and next both occupied
    stim.delete();
    stim.push_back('{data: 32'h0000_00C0, reps: 7});
    run_stream(1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_underrun", 32'(underrun_out), 32'd1);
    feed_stalled(32'h0000_00B1);
    feed_stalled(32'h0000_00B2);
    check_eq("both_full_tvalid", 32'(upsample_axis_tvalid), 32'd1);
    check_eq("both_full_tready", 32'(signal_axis_tready), 32'd0);
    #2 rst_in = 1'b1;
    #1;
    check_eq("async_tvalid", 32'(upsample_axis_tvalid), 32'd0);
    check_eq("async_underrun", 32'(underrun_out), 32'd0);
    q_exp.delete();
    prev_stall = 1'b0;
    upsample_axis_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    check_eq("post_rst_tready", 32'(signal_axis_tready), 32'd1);
    stim.delete();
    stim.push_back('{data: 32'h0000_00D0, reps: 7});
    beats = 0;
    run_stream(1'b0, 1'b1, 1'b0);
    idle(5);
    check_eq("post_rst_beats", 32'(beats), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
